// File: rtl/seq_pkg.sv
// Shared definitions for the serial stimulus transmitter and the detector benches.
// State encodings double as the detector benches' currstate decode values.
package seq_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'b00,
        ST_SHIFT = 2'b01,
        ST_GAP   = 2'b10,
        ST_DONE  = 2'b11
    } tx_state_e;

    localparam logic [1:0] SEQ_IDLE  = 2'b00;
    localparam logic [1:0] SEQ_SHIFT = 2'b01;
    localparam logic [1:0] SEQ_GAP   = 2'b10;
    localparam logic [1:0] SEQ_DONE  = 2'b11;

    localparam int DEF_PAT_W   = 8;
    localparam int DEF_GAP_CYC = 2;

    // Counter width able to hold n-1, never narrower than one bit.
    function automatic int cnt_w(input int n);
        return (n < 2) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/seq_shift_reg.sv
// Loadable MSB-first left shifter with a captured copy for repetitions.
// Build option SEQ_STREAM_TX_PARITY_EN adds the copy's even-parity output.
module seq_shift_reg #(
    parameter int PAT_W = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             load,
    input  logic             shift,
    input  logic             reload,
    input  logic [PAT_W-1:0] load_val,
    output logic             msb,
    output logic             copy_msb
`ifdef SEQ_STREAM_TX_PARITY_EN
    ,
    output logic             copy_par
`endif
);

    logic [PAT_W-1:0] shreg_q, shreg_d;
    logic [PAT_W-1:0] copy_q, copy_d;

    // load and reload present bit PAT_W-1 in the same edge, so store the remainder pre-shifted
    always_comb begin
        shreg_d = shreg_q;
        copy_d  = copy_q;
        if (load) begin
            shreg_d = load_val << 1;
            copy_d  = load_val;
        end else if (reload) begin
            shreg_d = copy_q << 1;
        end else if (shift) begin
            shreg_d = shreg_q << 1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            shreg_q <= '0;
            copy_q  <= '0;
        end else begin
            shreg_q <= shreg_d;
            copy_q  <= copy_d;
        end
    end

    assign msb      = shreg_q[PAT_W-1];
    assign copy_msb = copy_q[PAT_W-1];
`ifdef SEQ_STREAM_TX_PARITY_EN
    assign copy_par = ^copy_q;
`endif

endmodule

// File: rtl/seq_stream_tx.sv
// Serial pattern transmitter feeding the FSM sequence detectors: MSB-first, repeated, gapped.
// Build option SEQ_STREAM_TX_PARITY_EN appends an even-parity bit to every frame.
module seq_stream_tx
    import seq_pkg::*;
#(
    parameter int PAT_W   = DEF_PAT_W,
    parameter int GAP_CYC = DEF_GAP_CYC,
    parameter int REP_W   = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic             abort,
    input  logic [PAT_W-1:0] pattern,
    input  logic [REP_W-1:0] rep_cnt,
    output logic             out_bit,
    output logic             out_valid,
    output logic             busy,
    output logic             done,
    output logic [1:0]       tx_state
);

`ifdef SEQ_STREAM_TX_PARITY_EN
    localparam int FRAME_W = PAT_W + 1;
`else
    localparam int FRAME_W = PAT_W;
`endif
    localparam int BIT_W = $clog2(FRAME_W + 1);
    localparam int GAP_W = cnt_w(GAP_CYC + 1);

    tx_state_e        state_q, state_d;
    logic [BIT_W-1:0] bit_cnt_q, bit_cnt_d;
    logic [GAP_W-1:0] gap_cnt_q, gap_cnt_d;
    logic [REP_W-1:0] reps_q, reps_d;
    logic             out_bit_q, out_bit_d;
    logic             out_valid_q, out_valid_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;

    logic sr_load, sr_shift, sr_reload;
    logic sr_msb, sr_copy_msb;
`ifdef SEQ_STREAM_TX_PARITY_EN
    logic sr_par;
`endif

    seq_shift_reg #(.PAT_W(PAT_W)) u_shreg (
        .clk      (clk),
        .rst_n    (rst_n),
        .load     (sr_load),
        .shift    (sr_shift),
        .reload   (sr_reload),
        .load_val (pattern),
        .msb      (sr_msb),
        .copy_msb (sr_copy_msb)
`ifdef SEQ_STREAM_TX_PARITY_EN
        ,
        .copy_par (sr_par)
`endif
    );

    // bit_cnt counts bits already on the output; the frame ends when it reaches FRAME_W
    always_comb begin
        state_d     = state_q;
        bit_cnt_d   = bit_cnt_q;
        gap_cnt_d   = gap_cnt_q;
        reps_d      = reps_q;
        out_bit_d   = 1'b0;
        out_valid_d = 1'b0;
        done_d      = 1'b0;
        sr_load     = 1'b0;
        sr_shift    = 1'b0;
        sr_reload   = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (start && !abort) begin
                    state_d     = ST_SHIFT;
                    sr_load     = 1'b1;
                    reps_d      = rep_cnt;
                    bit_cnt_d   = BIT_W'(1);
                    out_bit_d   = pattern[PAT_W-1];
                    out_valid_d = 1'b1;
                end
            end
            ST_SHIFT: begin
                if (bit_cnt_q != BIT_W'(FRAME_W)) begin
                    out_valid_d = 1'b1;
                    bit_cnt_d   = bit_cnt_q + BIT_W'(1);
                    out_bit_d   = sr_msb;
                    sr_shift    = 1'b1;
`ifdef SEQ_STREAM_TX_PARITY_EN
                    if (bit_cnt_q == BIT_W'(PAT_W)) begin
                        out_bit_d = sr_par;
                        sr_shift  = 1'b0;
                    end
`endif
                end else if (reps_q != '0) begin
                    reps_d = reps_q - REP_W'(1);
                    if (GAP_CYC == 0) begin
                        sr_reload   = 1'b1;
                        bit_cnt_d   = BIT_W'(1);
                        out_bit_d   = sr_copy_msb;
                        out_valid_d = 1'b1;
                    end else begin
                        state_d   = ST_GAP;
                        gap_cnt_d = GAP_W'(1);
                    end
                end else begin
                    state_d = ST_DONE;
                    done_d  = 1'b1;
                end
            end
            ST_GAP: begin
                if (gap_cnt_q == GAP_W'(GAP_CYC)) begin
                    state_d     = ST_SHIFT;
                    sr_reload   = 1'b1;
                    bit_cnt_d   = BIT_W'(1);
                    out_bit_d   = sr_copy_msb;
                    out_valid_d = 1'b1;
                end else begin
                    gap_cnt_d = gap_cnt_q + GAP_W'(1);
                end
            end
            ST_DONE: state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase

        if (abort && state_q != ST_IDLE) begin
            state_d     = ST_IDLE;
            out_bit_d   = 1'b0;
            out_valid_d = 1'b0;
            done_d      = 1'b0;
            sr_load     = 1'b0;
            sr_shift    = 1'b0;
            sr_reload   = 1'b0;
        end

        busy_d = (state_d != ST_IDLE);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= ST_IDLE;
            bit_cnt_q   <= '0;
            gap_cnt_q   <= '0;
            reps_q      <= '0;
            out_bit_q   <= 1'b0;
            out_valid_q <= 1'b0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            bit_cnt_q   <= bit_cnt_d;
            gap_cnt_q   <= gap_cnt_d;
            reps_q      <= reps_d;
            out_bit_q   <= out_bit_d;
            out_valid_q <= out_valid_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
        end
    end

    assign out_bit   = out_bit_q;
    assign out_valid = out_valid_q;
    assign busy      = busy_q;
    assign done      = done_q;
    assign tx_state  = state_q;

endmodule
